// File: rtl/prbs5_checker.sv
// PRBS-5 (x^5 + x^2 + 1) serial checker: self-synchronises in HUNT, then flywheels in LOCK and counts bit errors.
// The error counter exists only when PRBS5_CHK_ERRCNT_EN is defined. d is consumed only on cycles with d_vld high (no backpressure).
module prbs5_checker #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_THR = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             d,
  input  logic             d_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t     state;
  logic [4:0] h;
  logic [2:0] fill;
  logic [4:0] match;
  logic [4:0] window;
  logic [4:0] win_err;
  logic       p;
  logic       mis;
  logic [4:0] win_err_inc;

  assign p           = h[2] ^ h[4];
  assign mis         = d ^ p;
  assign win_err_inc = win_err + {4'd0, mis};

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state   <= HUNT;
      h       <= 5'd0;
      fill    <= 3'd0;
      match   <= 5'd0;
      window  <= 5'd0;
      win_err <= 5'd0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (d_vld) begin
        case (state)
          HUNT: begin
            h <= {h[3:0], d};
            // All-zero history is the LFSR lockup pattern and would predict zeros forever.
            if (fill != 3'd5) begin
              fill <= fill + 3'd1;
            end else if (h == 5'd0 || mis) begin
              match <= 5'd0;
            end else if (match + 5'd1 == 5'(LOCK_CNT)) begin
              state   <= LOCK;
              locked  <= 1'b1;
              match   <= 5'd0;
              window  <= 5'd0;
              win_err <= 5'd0;
            end else begin
              match <= match + 5'd1;
            end
          end
          LOCK: begin
            // Shift in the prediction so a single line error cannot corrupt later predictions.
            h   <= {h[3:0], p};
            err <= mis;
            if (win_err_inc == 5'(LOSS_THR)) begin
              state   <= HUNT;
              locked  <= 1'b0;
              h       <= 5'd0;
              fill    <= 3'd0;
              match   <= 5'd0;
              window  <= 5'd0;
              win_err <= 5'd0;
            end else if (window == 5'd30) begin
              window  <= 5'd0;
              win_err <= 5'd0;
            end else begin
              window  <= window + 5'd1;
              win_err <= win_err_inc;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef PRBS5_CHK_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // clr wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (d_vld && state == LOCK && mis && err_cnt != {CNT_W{1'b1}}) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end
`else
  logic unused_clr;

  assign err_cnt    = '0;
  assign unused_clr = clr;
`endif

endmodule

// File: doc/prbs5_checker.md
# prbs5_checker

Serial PRBS-5 receiver/checker: the receive-side counterpart of the team's 5-bit LFSR pattern generator (polynomial x^5 + x^2 + 1, period 31). It self-synchronises to an incoming bit stream, declares lock, then flywheels on its own prediction and counts bit errors. It sits at the far end of a serial test link for BER and link-integrity checks.

## Interface
- LOCK_CNT, 8: consecutive correct predictions in HUNT required to lock (range 1..31).
- LOSS_THR, 4: mismatches within one 31-bit window in LOCK that force loss of lock (range 1..31).
- CNT_W, 16: width of the error counter.

- clk  in  1  single clock, all logic on its rising edge.
- rst_b  in  1  reset, synchronous, active-low.
- d  in  1  received serial bit.
- d_vld  in  1  d is valid this cycle; all state holds when low.
- clr  in  1  synchronous clear of err_cnt.
- locked  out  1  checker is in LOCK.
- err  out  1  one-cycle pulse: mismatch on the previous valid bit while locked.
- err_cnt  out  CNT_W  saturating count of mismatches while locked.

## Operation
- Recurrence: o(n) = o(n-3) XOR o(n-5). History h[4:0], h[0] = newest bit; prediction p = h[2] ^ h[4].
- Reset (rst_b low at an edge): state HUNT, h = 0, fill = 0, match = 0, window = 0, win_err = 0, locked = 0, err = 0, err_cnt = 0.
- HUNT, on each d_vld:
  - h shifts in received d.
  - fill increments, saturating at 5; no comparison while fill < 5.
  - fill = 5 and h != 0: d == p increments match; d != p clears match. No err, no counting.
  - h == 0 (lockup pattern): match cleared, no comparison.
  - match reaching LOCK_CNT moves to LOCK, with window = 0 and win_err = 0.
- LOCK, on each d_vld:
  - h shifts in p (flywheel), not d, so one line error gives exactly one mismatch.
  - d != p: err pulses, err_cnt += 1 (saturates at all-ones), win_err += 1.
  - window counts 0..30; on the 31st valid bit it wraps to 0 and win_err clears (the update for that bit is applied first).
  - win_err reaching LOSS_THR: move to HUNT and clear h, fill, match; that bit is discarded.
- clr: err_cnt becomes 0 and takes priority over a same-cycle increment. The err pulse is still issued.
- d_vld low: no state change; err low.

## Timing
- All outputs are registered.
- err is high in the cycle after the edge that sampled the mismatching bit, for exactly one cycle.
- locked rises in the cycle after the edge that sampled the LOCK_CNT-th consecutive match.
- locked falls in the cycle after the edge that sampled the mismatch bringing win_err to LOSS_THR. err also pulses for that bit.
- Minimum time to lock from reset with a clean stream: 5 + LOCK_CNT valid bits.
- A reset asserted mid-operation takes effect at the next edge regardless of d_vld.

## Configuration
- PRBS5_CHK_ERRCNT_EN defined: err_cnt and clr behave as above.
- Not defined: no counter register, err_cnt is tied to 0 and clr is ignored. locked, err and lock/loss behaviour are unchanged.

## Test plan
- Clean stream, generator seeded 5'b00001 (bits 0,0,0,0,1,0,0,1,0,...), d_vld always high, defaults -> locked rises after bit 13, then no err and err_cnt = 0 over 1000 bits.
- Locked, invert one bit -> exactly one err pulse, err_cnt = 1, locked stays high. Next correct bit -> no err (flywheel).
- Locked, invert 4 bits within 31 -> locked falls the cycle after the 4th error, err_cnt = 4. Clean stream resumes -> relock after 13 more valid bits.
- All-zero input for 100 bits after reset -> locked stays 0, err never asserts.
- d_vld toggled every other cycle on a clean stream -> lock after 13 valid bits. Then clr asserted on the same cycle as an error -> err pulses, err_cnt = 0.
- CNT_W = 2, 5 isolated errors (one per window) -> err_cnt saturates at 3. Reset mid-LOCK -> locked = 0 and err_cnt = 0 the next cycle.
